// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle between the datapath (master) and the hazard/forwarding unit (slave).
interface hazard_fwd_unit_if #(
    parameter int REG_BITS = 5,
    parameter int NUM_SRC  = 2,
    parameter int NSTAGE   = 2,
    parameter int CNT_W    = 16
);
    localparam int SEL_W = $clog2(NSTAGE + 1);

    logic                         id_valid;
    logic [NUM_SRC*REG_BITS-1:0]  id_rs;
    logic [NUM_SRC-1:0]           id_rs_used;
    logic [REG_BITS-1:0]          id_rd;
    logic                         id_regwrite;
    logic                         id_memread;
    logic                         id_branch;
    logic                         id_redirect;

    logic                         stall;
    logic                         bubble_ex;
    logic                         flush_if_id;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
    logic [CNT_W-1:0]             stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_branch, id_redirect,
        input  stall, bubble_ex, flush_if_id, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_branch, id_redirect,
        output stall, bubble_ex, flush_if_id, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight writers (EX + NSTAGE post-EX stages)
// driving EX forwarding selects, load-use / ID-branch stalls, IF/ID flush and a stall counter.
module hazard_fwd_unit #(
    parameter int REG_BITS   = 5,
    parameter int NUM_SRC    = 2,
    parameter int NSTAGE     = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_fwd_unit_if.slave   hif
);
    localparam int SEL_W = $clog2(NSTAGE + 1);

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic [REG_BITS-1:0] rd;
    } slot_t;

    // Index 0 is the EX slot, index k is post-EX stage k.
    slot_t                       slot_q [NSTAGE+1];
    slot_t                       slot_d [NSTAGE+1];
    logic [NUM_SRC*REG_BITS-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]          ex_used_q, ex_used_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        stall;

    function automatic logic writes_reg(slot_t s, logic [REG_BITS-1:0] r);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
    endfunction

    always_comb begin : hazard_detect
        logic load_use;
        logic br_stall;
        load_use = 1'b0;
        br_stall = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (hif.id_rs_used[i]) begin
                for (int unsigned d = 0; d <= NSTAGE; d++) begin
                    if (writes_reg(slot_q[d], hif.id_rs[i*REG_BITS +: REG_BITS])) begin
                        if (slot_q[d].memread && (d + 1 < LOAD_STAGE)) load_use = 1'b1;
                        if (hif.id_branch && (d < NSTAGE))             br_stall = 1'b1;
                    end
                end
            end
        end
        stall = hif.id_valid && (load_use || br_stall);
    end

    always_comb begin : fwd_select
        hif.fwd_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (slot_q[0].valid && ex_used_q[i]) begin
                // Walk farthest-first so the nearest qualifying stage is the one that sticks.
                for (int unsigned k = NSTAGE; k >= 1; k--) begin
                    if (writes_reg(slot_q[k], ex_rs_q[i*REG_BITS +: REG_BITS]) &&
                        (!slot_q[k].memread || (k >= LOAD_STAGE)))
                        hif.fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin : next_state
        slot_d[0] = '0;
        ex_rs_d   = ex_rs_q;
        ex_used_d = ex_used_q;
        if (hif.id_valid && !stall) begin
            slot_d[0].valid    = 1'b1;
            slot_d[0].regwrite = hif.id_regwrite;
            slot_d[0].memread  = hif.id_memread;
            slot_d[0].rd       = hif.id_rd;
            ex_rs_d            = hif.id_rs;
            ex_used_d          = hif.id_rs_used;
        end
        for (int unsigned k = 1; k <= NSTAGE; k++) slot_d[k] = slot_q[k-1];
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= NSTAGE; k++) slot_q[k] <= '0;
            ex_rs_q   <= '0;
            ex_used_q <= '0;
            cnt_q     <= '0;
        end else begin
            slot_q    <= slot_d;
            ex_rs_q   <= ex_rs_d;
            ex_used_q <= ex_used_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hif.stall       = stall;
    assign hif.bubble_ex   = stall;
    assign hif.flush_if_id = hif.id_valid && hif.id_redirect && !stall;
    assign hif.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two configurations (NSTAGE=2/LOAD_STAGE=2 and NSTAGE=3/LOAD_STAGE=3,
// narrow counter) fed identical ID streams and checked against an instruction-age reference model.
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       id_valid, id_regwrite, id_memread, id_branch, id_redirect;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;

    hazard_fwd_unit_if #(.REG_BITS(5), .NUM_SRC(2), .NSTAGE(2), .CNT_W(16)) if_a ();
    hazard_fwd_unit_if #(.REG_BITS(5), .NUM_SRC(2), .NSTAGE(3), .CNT_W(3))  if_b ();

    assign if_a.id_valid = id_valid;       assign if_b.id_valid = id_valid;
    assign if_a.id_rs = id_rs;             assign if_b.id_rs = id_rs;
    assign if_a.id_rs_used = id_rs_used;   assign if_b.id_rs_used = id_rs_used;
    assign if_a.id_rd = id_rd;             assign if_b.id_rd = id_rd;
    assign if_a.id_regwrite = id_regwrite; assign if_b.id_regwrite = id_regwrite;
    assign if_a.id_memread = id_memread;   assign if_b.id_memread = id_memread;
    assign if_a.id_branch = id_branch;     assign if_b.id_branch = id_branch;
    assign if_a.id_redirect = id_redirect; assign if_b.id_redirect = id_redirect;

    hazard_fwd_unit #(.REG_BITS(5), .NUM_SRC(2), .NSTAGE(2), .LOAD_STAGE(2), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .hif(if_a));
    hazard_fwd_unit #(.REG_BITS(5), .NUM_SRC(2), .NSTAGE(3), .LOAD_STAGE(3), .CNT_W(3))
        dut_b (.clk(clk), .rst(rst), .hif(if_b));

    // Reference model: per config, the instruction that entered EX d cycles ago sits at age d.
    typedef struct {
        bit v, rw, mr, u0, u1, br, redir;
        int rd, rs0, rs1;
    } ins_t;

    ins_t cur;
    ins_t hist [2][4];
    int   cnt  [2];
    bit   est  [2];
    int   passed = 0;
    int   total  = 0;

    function automatic int nstage(int c);   return (c != 0) ? 3 : 2; endfunction
    function automatic int load_stg(int c); return (c != 0) ? 3 : 2; endfunction
    function automatic int cnt_max(int c);  return (c != 0) ? 7 : 65535; endfunction

    function automatic bit produces(ins_t e, int r);
        return e.v && e.rw && (e.rd != 0) && (e.rd == r);
    endfunction

    // An ID read of a register stalls if its producer is a load whose data is not
    // yet ready one cycle from now, or if a branch needs it before it reaches the regfile.
    function automatic bit exp_stall(int c);
        bit s;
        s = 0;
        for (int d = 0; d <= nstage(c); d++) begin
            if ((cur.u0 && produces(hist[c][d], cur.rs0)) || (cur.u1 && produces(hist[c][d], cur.rs1))) begin
                if (hist[c][d].mr && (d + 1 < load_stg(c))) s = 1;
                if (cur.br && (d < nstage(c)))             s = 1;
            end
        end
        return cur.v && s;
    endfunction

    function automatic int exp_fwd(int c, int src);
        ins_t ex;
        int   r;
        bit   u;
        ex = hist[c][0];
        r  = (src != 0) ? ex.rs1 : ex.rs0;
        u  = (src != 0) ? ex.u1 : ex.u0;
        if (!ex.v || !u) return 0;
        for (int k = 1; k <= nstage(c); k++)
            if (produces(hist[c][k], r) && (!hist[c][k].mr || k >= load_stg(c))) return k;
        return 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_cfg(input int c, input int st, input int bub, input int fl,
                             input int f0, input int f1, input int sc);
        string p;
        p = (c != 0) ? "b." : "a.";
        chk({p, "stall"},       st,  int'(est[c]));
        chk({p, "bubble_ex"},   bub, int'(est[c]));
        chk({p, "flush_if_id"}, fl,  int'(cur.v && cur.redir && !est[c]));
        chk({p, "fwd_sel0"},    f0,  exp_fwd(c, 0));
        chk({p, "fwd_sel1"},    f1,  exp_fwd(c, 1));
        chk({p, "stall_cnt"},   sc,  cnt[c]);
    endtask

    task automatic set_id(input bit v, input int rd, input bit rw, input bit mr, input int rs0,
                          input int rs1, input bit u0, input bit u1, input bit br, input bit redir);
        cur.v = v;  cur.rd = rd;   cur.rw = rw;   cur.mr = mr;  cur.rs0 = rs0; cur.rs1 = rs1;
        cur.u0 = u0; cur.u1 = u1;  cur.br = br;   cur.redir = redir;
        id_valid = v; id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
        id_rs = {5'(rs1), 5'(rs0)}; id_rs_used = {u1, u0};
        id_branch = br; id_redirect = redir;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk);
        for (int c = 0; c < 2; c++) est[c] = exp_stall(c);
        check_cfg(0, if_a.stall, if_a.bubble_ex, if_a.flush_if_id, if_a.fwd_sel[1:0],
                  if_a.fwd_sel[3:2], if_a.stall_cnt);
        check_cfg(1, if_b.stall, if_b.bubble_ex, if_b.flush_if_id, if_b.fwd_sel[1:0],
                  if_b.fwd_sel[3:2], if_b.stall_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) hist[c][k] = '{default: 0};
                cnt[c] = 0;
            end else begin
                for (int k = 3; k >= 1; k--) hist[c][k] = hist[c][k-1];
                if (cur.v && !est[c]) hist[c][0] = cur;
                else                  hist[c][0] = '{default: 0};
                if (est[c] && cnt[c] < cnt_max(c)) cnt[c]++;
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int c = 0; c < 2; c++) est[c] = 0;
        advance();
        advance();
        rst = 1'b0;

        // reset state
        sample();
        chk("rst.stall", if_a.stall, 0);
        chk("rst.cnt", if_a.stall_cnt, 0);
        advance();

        // 1: add r3 ; add r4,r3,r1
        set_id(1, 3, 1, 0, 1, 2, 1, 1, 0, 0); tick();
        set_id(1, 4, 1, 0, 3, 1, 1, 1, 0, 0); tick();
        idle(); sample();
        chk("t1.fwd0", if_a.fwd_sel[1:0], 1);
        chk("t1.stall", if_a.stall, 0);
        advance();

        // 2: add r3 ; nop ; sub r5,r3,r3
        set_id(1, 3, 1, 0, 1, 2, 1, 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 0, 3, 3, 1, 1, 0, 0); tick();
        idle(); sample();
        chk("t2.fwd0", if_a.fwd_sel[1:0], 2);
        chk("t2.fwd1", if_a.fwd_sel[3:2], 2);
        advance();

        // 3: lw r2 ; add r6,r2,r2
        set_id(1, 2, 1, 1, 1, 0, 1, 0, 0, 0); tick();
        set_id(1, 6, 1, 0, 2, 2, 1, 1, 0, 0); sample();
        chk("t3.stall_first", if_a.stall, 1);
        chk("t3.bubble_first", if_a.bubble_ex, 1);
        chk("t3.b_stall_first", if_b.stall, 1);
        advance(); sample();
        chk("t3.stall_second", if_a.stall, 0);
        chk("t3.b_stall_second", if_b.stall, 1);
        advance();
        idle(); sample();
        chk("t3.fwd0", if_a.fwd_sel[1:0], 2);
        chk("t3.cnt", if_a.stall_cnt, 1);
        advance();

        // 4: add r7 ; beq r7,r0 resolving taken
        set_id(1, 7, 1, 0, 1, 2, 1, 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 7, 0, 1, 1, 1, 1); sample();
        chk("t4.stall_c1", if_a.stall, 1);
        chk("t4.flush_c1", if_a.flush_if_id, 0);
        advance(); sample();
        chk("t4.stall_c2", if_a.stall, 1);
        advance(); sample();
        chk("t4.stall_c3", if_a.stall, 0);
        chk("t4.flush_c3", if_a.flush_if_id, 1);
        advance();
        idle(); sample();
        chk("t4.flush_after", if_a.flush_if_id, 0);
        advance();

        // 5: r0 writer never forwards; nearest of two r8 writers wins
        set_id(1, 0, 1, 0, 1, 2, 1, 1, 0, 0); tick();
        set_id(1, 9, 1, 0, 0, 0, 1, 1, 0, 0); tick();
        idle(); sample();
        chk("t5.r0_fwd", if_a.fwd_sel[1:0], 0);
        advance();
        set_id(1, 8, 1, 0, 1, 2, 1, 1, 0, 0); tick();
        set_id(1, 8, 1, 0, 3, 4, 1, 1, 0, 0); tick();
        set_id(1, 10, 1, 0, 8, 1, 1, 1, 0, 0); tick();
        idle(); sample();
        chk("t5.r8_nearest", if_a.fwd_sel[1:0], 1);
        advance();

        // counter saturation on the narrow-counter config
        for (int n = 0; n < 3; n++) begin
            set_id(1, 9, 1, 0, 1, 2, 1, 1, 0, 0); tick();
            set_id(1, 0, 0, 0, 9, 0, 1, 0, 1, 0);
            for (int j = 0; j < 4; j++) tick();
        end
        idle(); sample();
        chk("sat.b_cnt", if_b.stall_cnt, 7);
        advance();

        // 6: reset in the middle of a load-use stall
        set_id(1, 2, 1, 1, 1, 0, 1, 0, 0, 0); tick();
        set_id(1, 6, 1, 0, 2, 2, 1, 1, 0, 0); sample();
        chk("t6.pre_stall", if_a.stall, 1);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        sample();
        chk("t6.stall", if_a.stall, 0);
        chk("t6.cnt", if_a.stall_cnt, 0);
        chk("t6.fwd", if_a.fwd_sel, 0);
        chk("t6.b_stall", if_b.stall, 0);
        advance();

        // randomized traffic over a small register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            set_id(($urandom % 8) != 0, $urandom % 6, $urandom % 2, ($urandom % 3) == 0,
                   $urandom % 6, $urandom % 6, $urandom % 2, $urandom % 2,
                   ($urandom % 4) == 0, ($urandom % 4) == 0);
            sample();
            rst = (($urandom % 97) == 0);
            advance();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
